// File: rtl/ms_timer_pkg.sv
// ms_timer_pkg: shared types and defaults for the millisecond timer blocks.
//   ch_state_e   - per-channel delay counter state
//   DEF_TICK_DIV - default clock cycles per ms tick
//   DEF_DELAY_W  - default width of a delay value, in ms
package ms_timer_pkg;

  localparam int unsigned DEF_TICK_DIV = 202;
  localparam int unsigned DEF_DELAY_W  = 16;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler producing a one-cycle tick every
// TICK_DIV clock cycles.
//   pulseClk - clock, rising edge
//   rst      - synchronous active-high reset
//   tick     - registered one-cycle pulse, high the cycle after presc wraps
module ms_tick_gen
  import ms_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic pulseClk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PW'(TICK_DIV - 1));

  // Prescaler and registered tick; never stops outside reset.
  always_ff @(posedge pulseClk) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) presc <= '0;
      else      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/ms_delay_scheduler.sv
// ms_delay_scheduler: shares one ms tick among NUM_CH requesters. A
// round-robin arbiter accepts at most one delay request per cycle; each
// accepted delay counts down in its own channel and pulses done on expiry.
//   pulseClk - clock, rising edge
//   rst      - synchronous active-high reset
//   req      - per-channel level request, held until ack
//   delay    - per-channel delay in ms, channel c at [c*DELAY_W +: DELAY_W]
//   cancel   - per-channel abort of a running delay
//   ack      - one-cycle pulse, request accepted (at most one per cycle)
//   busy     - channel is counting
//   done     - one-cycle pulse, delay expired
//   tick     - one-cycle pulse per ms, free-running
module ms_delay_scheduler
  import ms_timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DELAY_W  = DEF_DELAY_W,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic                        pulseClk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           req,
  input  logic [NUM_CH*DELAY_W-1:0]   delay,
  input  logic [NUM_CH-1:0]           cancel,
  output logic [NUM_CH-1:0]           ack,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           done,
  output logic                        tick
);

  localparam int unsigned PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  scan_idx;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              grant_valid;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant_oh;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .pulseClk (pulseClk),
    .rst      (rst),
    .tick     (tick)
  );

  // A channel acked this cycle is still loading, so it is excluded too.
  assign elig = req & ~busy & ~cancel & ~ack;

  // Round-robin search starting at rr_ptr, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    grant_oh    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_idx = PTR_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!grant_valid && elig[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Registered ack and pointer advance past the granted channel.
  always_ff @(posedge pulseClk) begin
    if (rst) begin
      ack    <= '0;
      rr_ptr <= '0;
    end else begin
      ack <= grant_oh;
      if (grant_valid) rr_ptr <= next_ptr;
    end
  end

  // Per-channel delay counters.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e          state;
    logic [DELAY_W-1:0] cnt;
    logic [DELAY_W-1:0] dly;
    logic               busy_r;
    logic               done_r;

    assign dly     = delay[c*DELAY_W +: DELAY_W];
    assign busy[c] = busy_r;
    assign done[c] = done_r;

    // Ticks in the ack cycle are ignored so a fresh load is never shortened.
    // Cancel has priority over the final decrement.
    always_ff @(posedge pulseClk) begin
      if (rst) begin
        state  <= CH_IDLE;
        cnt    <= '0;
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        case (state)
          CH_IDLE: begin
            if (grant_oh[c]) begin
              if (dly != '0) begin
                state  <= CH_RUN;
                cnt    <= dly;
                busy_r <= 1'b1;
              end else begin
                done_r <= 1'b1;
              end
            end
          end
          CH_RUN: begin
            if (cancel[c]) begin
              state  <= CH_IDLE;
              cnt    <= '0;
              busy_r <= 1'b0;
            end else if (tick && !ack[c]) begin
              if (cnt == DELAY_W'(1)) begin
                state  <= CH_IDLE;
                cnt    <= '0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                cnt <= cnt - DELAY_W'(1);
              end
            end
          end
          default: state <= CH_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ms_delay_scheduler.md
# ms_delay_scheduler

Shares one millisecond tick source among `NUM_CH` requesters, each of which needs an independent millisecond delay. A round-robin arbiter accepts at most one delay request per cycle. Each accepted delay runs as an independent per-channel down-counter, and a one-cycle `done` pulse fires when it expires. The block sits between the game/control FSMs and the tick timing in the LFSR timer path, so those FSMs no longer each carry their own prescaled counter.

## Interface
Parameters:
- `NUM_CH`, 4: number of requester channels (2..8).
- `DELAY_W`, 16: width of a delay value, in ms.
- `TICK_DIV`, 202: `pulseClk` cycles per ms tick (≥2).

Ports:
- `pulseClk` in 1: sole clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_CH`: level request per channel; held until `ack`.
- `delay` in `NUM_CH*DELAY_W`: per-channel delay; channel c occupies bits `[c*DELAY_W +: DELAY_W]`. Sampled in the grant cycle.
- `cancel` in `NUM_CH`: abort a running delay.
- `ack` out `NUM_CH`: one-cycle pulse; the request was accepted.
- `busy` out `NUM_CH`: channel is counting.
- `done` out `NUM_CH`: one-cycle pulse; the delay expired.
- `tick` out 1: one-cycle pulse per ms, free-running.

## Operation
- Prescaler:
  - `presc` counts 0..`TICK_DIV-1` and wraps.
  - `tick` is registered; it is high in the cycle after `presc == TICK_DIV-1`.
  - The prescaler never stops; it is independent of channel activity.
- Per-channel FSM, two states: `IDLE` (busy=0) and `RUN` (busy=1). Each channel has its own `cnt[DELAY_W]`.
- Arbiter:
  - Eligible channels are those with `req[c]=1`, `busy[c]=0`, `cancel[c]=0` and no `ack[c]` in the current cycle.
  - Search starts at `rr_ptr` and wraps; the first eligible channel c is granted.
  - On a grant, the next edge produces:
    - `ack[c]=1`;
    - `rr_ptr = (c+1) mod NUM_CH`.
    - If `delay_c ≠ 0`: `cnt=delay_c` and state `RUN`.
    - If `delay_c = 0`: `done[c]=1` in the same cycle as `ack`, and the channel stays `IDLE`.
  - With no eligible channel, `rr_ptr` holds.
- Countdown:
  - In `RUN`, on a cycle where `tick=1`, `cnt` decrements.
  - When `cnt==1` and `tick=1`, the next edge produces `cnt=0`, state `IDLE`, `busy=0` and `done=1`.
- Load vs tick: a tick in the ack cycle does not decrement. Measured expiry is therefore between `delay-1` and `delay` ms after `ack`.
- Cancel:
  - `cancel[c]=1` while `RUN`: the next edge goes to `IDLE` and clears `cnt`; no `done` is produced.
  - `cancel` on an `IDLE` channel blocks its grant that cycle and has no other effect.
  - Cancel coincident with final expiry: cancel wins, so no `done`.
- Re-request: if `req[c]` is still high after `done`, or after `cancel`, the channel is eligible again. Holding `req` high gives a periodic timer.
- Reset:
  - `ack`, `busy`, `done` and `tick` are 0.
  - All `cnt` are 0, all states are `IDLE`.
  - `rr_ptr` and `presc` are 0.
  - Reset mid-delay discards it silently, with no `done`.

## Timing
- Request to `ack`: 1 cycle when uncontested.
  - Worst case is `NUM_CH` cycles while others are also requesting.
  - That worst case applies only to channels whose `busy` is already low.
- Only one `ack` is asserted per cycle. `done` may assert on several channels in the same cycle.
- After reset release, the first `tick` is at cycle `TICK_DIV` (cycle 1 is the first edge with `rst=0`).
- `busy` rises in the `ack` cycle and falls in the `done` cycle.
- Arithmetic:
  - `cnt` is unsigned and never underflows, because it only decrements when ≥1.
  - The prescaler width is `$clog2(TICK_DIV)`.

## Structure
- Shared package `ms_timer_pkg`:
  - channel state enum `{CH_IDLE, CH_RUN}`;
  - default `TICK_DIV` and `DELAY_W` constants.
- Sub-module `ms_tick_gen`: the prescaler plus the registered `tick` output. It is reusable by other timer blocks.
- Top level holds the round-robin arbiter and a generate loop of the per-channel counter FSMs.

## Test plan
Bench parameters: `NUM_CH=4`, `TICK_DIV=4`.
- Reset, then idle for 12 cycles: `tick` pulses at cycles 4, 8 and 12; all other outputs stay 0.
- Single request, `req[0]`, `delay0=3` → `ack[0]` next cycle; `done[0]` on the 3rd tick after `ack`; `busy[0]` high exactly from `ack` through the cycle before `done`.
- Contention, `req=4'b1111` asserted together with `rr_ptr=0` → `ack` order is channel 0, 1, 2, 3 on consecutive cycles; then a new `req[1]` and `req[3]` pair is served 1 then 3 (`rr_ptr` has wrapped to 0).
- Zero delay, `delay2=0` → `ack[2]` and `done[2]` in the same cycle; `busy[2]` never asserts.
- Cancel, `delay1=5`, `cancel[1]` after 2 ticks → `busy[1]` drops next cycle and no `done[1]` follows. A cancel in the exact expiry cycle also suppresses `done`.
- Periodic and reset, `req[3]` held with `delay3=2` → `done[3]` about every 2 ticks. Asserting `rst` mid-count clears `busy` next edge with no `done`.
